// File: rtl/decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_unit
// Description : RV32I control decoder with E-stage pipeline register, mul/div
//               occupancy FSM (optional, macro DECODE_MULDIV_EN) and a
//               saturating illegal-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ALUCTRL_WIDTH  = 5,
   parameter int MULDIV_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    InstrD,
   input  logic                     ValidD,
   input  logic                     StallE,
   input  logic                     FlushE,
   output logic                     RegWriteE,
   output logic [1:0]               ResultSrcE,
   output logic                     MemWriteE,
   output logic                     JumpE,
   output logic                     BranchE,
   output logic [ALUCTRL_WIDTH-1:0] ALUControlE,
   output logic                     ALUSrcE,
   output logic [2:0]               ImmSrcE,
   output logic                     JALRInstrE,
   output logic [2:0]               AddressingControlE,
   output logic                     MulDivE,
   output logic                     ValidE,
   output logic                     IllegalE,
   output logic                     BusyD,
   output logic [15:0]              IllegalCount
);

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [4:0] alu;
      logic       alu_src;
      logic [2:0] imm_src;
      logic       jalr;
      logic [2:0] addr_ctrl;
      logic       muldiv;
   } ctrl_t;

   typedef enum logic [0:0] {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

   localparam logic [3:0] MD_LOAD  = 4'(MULDIV_LATENCY - 1);
   localparam bit         MD_MULTI = (MULDIV_LATENCY > 1);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   ctrl_t       dec;
   logic        illegal;
   ctrl_t       ctrl_e;
   logic        valid_e;
   logic        illegal_e;
   logic [15:0] illegal_cnt;
   state_t      state;
   logic [3:0]  md_cnt;
   logic        load_e;
   logic        unused_bits;

   assign opcode      = InstrD[6:0];
   assign funct3      = InstrD[14:12];
   assign funct7      = InstrD[31:25];
   assign unused_bits = ^{InstrD[24:15], InstrD[11:7]};

   generate
      if (DATA_WIDTH > 32) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^InstrD[DATA_WIDTH-1:32];
      end
   endgenerate

   always_comb begin
      dec     = '0;
      illegal = 1'b0;
      case (opcode)
         7'b0110011: begin
            case (funct7)
               7'b0000000: begin
                  dec.reg_write = 1'b1;
                  case (funct3)
                     3'b000:  dec.alu = 5'd0;
                     3'b001:  dec.alu = 5'd7;
                     3'b010:  dec.alu = 5'd5;
                     3'b011:  dec.alu = 5'd6;
                     3'b100:  dec.alu = 5'd4;
                     3'b101:  dec.alu = 5'd8;
                     3'b110:  dec.alu = 5'd3;
                     default: dec.alu = 5'd2;
                  endcase
               end
               7'b0100000: begin
                  dec.reg_write = 1'b1;
                  if (funct3 == 3'b000)      dec.alu = 5'd1;
                  else if (funct3 == 3'b101) dec.alu = 5'd11;
                  else                       illegal = 1'b1;
               end
`ifdef DECODE_MULDIV_EN
               7'b0000001: begin
                  dec.reg_write = 1'b1;
                  dec.muldiv    = 1'b1;
                  dec.alu       = {2'b10, funct3};
               end
`else
               7'b0000001: illegal = 1'b1;
`endif
               default: illegal = 1'b1;
            endcase
         end
         7'b0010011: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            case (funct3)
               3'b000:  dec.alu = 5'd0;
               3'b001:  dec.alu = 5'd7;
               3'b010:  dec.alu = 5'd5;
               3'b011:  dec.alu = 5'd6;
               3'b100:  dec.alu = 5'd4;
               3'b101:  dec.alu = InstrD[30] ? 5'd11 : 5'd8;
               3'b110:  dec.alu = 5'd3;
               default: dec.alu = 5'd2;
            endcase
         end
         7'b0000011: begin
            dec.result_src = 2'b01;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
            dec.addr_ctrl  = funct3;
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         7'b0100011: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b001;
            dec.addr_ctrl = funct3;
            illegal = (funct3 > 3'b010);
         end
         7'b1100011: begin
            dec.branch  = 1'b1;
            dec.alu     = 5'd1;
            dec.imm_src = 3'b010;
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         7'b1101111: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            dec.imm_src    = 3'b011;
         end
         7'b1100111: begin
            dec.jump       = 1'b1;
            dec.jalr       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src    = 1'b1;
            illegal = (funct3 != 3'b000);
         end
         7'b0110111: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.imm_src   = 3'b100;
            dec.alu       = 5'd15;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign load_e = !FlushE && !StallE && !BusyD;

   // Illegal or bubble instructions enter E with every control cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e      <= '0;
         valid_e     <= 1'b0;
         illegal_e   <= 1'b0;
         illegal_cnt <= '0;
      end else if (FlushE) begin
         ctrl_e    <= '0;
         valid_e   <= 1'b0;
         illegal_e <= 1'b0;
      end else if (load_e) begin
         ctrl_e    <= (ValidD && !illegal) ? dec : '0;
         valid_e   <= ValidD;
         illegal_e <= ValidD && illegal;
         if (ValidD && illegal && (illegal_cnt != 16'hFFFF))
            illegal_cnt <= illegal_cnt + 16'd1;
      end
   end

   // Occupancy counter keeps running through StallE; only FlushE aborts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_e && ValidD && !illegal && dec.muldiv && MD_MULTI) begin
                  state  <= MD_BUSY;
                  md_cnt <= MD_LOAD;
               end
            end
            MD_BUSY: begin
               if (FlushE || (md_cnt == 4'd1)) begin
                  state  <= IDLE;
                  md_cnt <= '0;
               end else begin
                  md_cnt <= md_cnt - 4'd1;
               end
            end
            default: begin
               state  <= IDLE;
               md_cnt <= '0;
            end
         endcase
      end
   end

`ifdef DECODE_MULDIV_EN
   assign BusyD = (state == MD_BUSY);
`else
   assign BusyD = 1'b0;
`endif

   assign RegWriteE          = ctrl_e.reg_write;
   assign ResultSrcE         = ctrl_e.result_src;
   assign MemWriteE          = ctrl_e.mem_write;
   assign JumpE              = ctrl_e.jump;
   assign BranchE            = ctrl_e.branch;
   assign ALUControlE        = ALUCTRL_WIDTH'(ctrl_e.alu);
   assign ALUSrcE            = ctrl_e.alu_src;
   assign ImmSrcE            = ctrl_e.imm_src;
   assign JALRInstrE         = ctrl_e.jalr;
   assign AddressingControlE = ctrl_e.addr_ctrl;
   assign MulDivE            = ctrl_e.muldiv;
   assign ValidE             = valid_e;
   assign IllegalE           = illegal_e;
   assign IllegalCount       = illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_unit
// Description : Directed and random checks of decode_ctrl_unit against a
//               table-driven reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_unit;

   localparam int LAT = 4;

`ifdef DECODE_MULDIV_EN
   localparam bit MD_ON = 1'b1;
`else
   localparam bit MD_ON = 1'b0;
`endif

   localparam logic [31:0] ADD = 32'h00B50533;
   localparam logic [31:0] SUB = 32'h40B50533;
   localparam logic [31:0] MUL = 32'h02B50533;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] InstrD = '0;
   logic        ValidD = 1'b0;
   logic        StallE = 1'b0;
   logic        FlushE = 1'b0;
   logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE;
   logic        MulDivE, ValidE, IllegalE, BusyD;
   logic [1:0]  ResultSrcE;
   logic [4:0]  ALUControlE;
   logic [2:0]  ImmSrcE, AddressingControlE;
   logic [15:0] IllegalCount;

   decode_ctrl_unit #(.DATA_WIDTH(32), .ALUCTRL_WIDTH(5), .MULDIV_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE),
      .FlushE(FlushE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ImmSrcE(ImmSrcE),
      .JALRInstrE(JALRInstrE), .AddressingControlE(AddressingControlE),
      .MulDivE(MulDivE), .ValidE(ValidE), .IllegalE(IllegalE), .BusyD(BusyD),
      .IllegalCount(IllegalCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       j;
      logic       b;
      logic [4:0] alu;
      logic       as;
      logic [2:0] imm;
      logic       jalr;
      logic [2:0] ac;
      logic       md;
      logic       v;
      logic       ill;
   } exp_t;

   logic [21:0] obs_e;
   assign obs_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                   ALUSrcE, ImmSrcE, JALRInstrE, AddressingControlE, MulDivE,
                   ValidE, IllegalE};

   int   checks = 0;
   int   errors = 0;
   exp_t exp_e = '0;
   int   busy_left = 0;
   int   exp_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural meaning of each instruction class, written as tables.
   function automatic exp_t ref_decode(input logic [31:0] ins);
      int   code_by_f3[8] = '{0, 7, 5, 6, 4, 8, 3, 2};
      exp_t d = '0;
      bit   ok = 1'b1;
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      case (ins[6:0])
         7'h33: begin
            if (f7 == 7'h00) begin d.rw = 1; d.alu = 5'(code_by_f3[f3]); end
            else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
               d.rw = 1; d.alu = (f3 == 0) ? 5'd1 : 5'd11;
            end
            else if (f7 == 7'h01 && MD_ON) begin d.rw = 1; d.md = 1; d.alu = 5'(16 + f3); end
            else ok = 0;
         end
         7'h13: begin
            d.rw = 1; d.as = 1;
            d.alu = (f3 == 5 && ins[30]) ? 5'd11 : 5'(code_by_f3[f3]);
         end
         7'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; d.rs = 1; d.as = 1; d.rw = 1; d.ac = f3; end
         7'h23: begin ok = (f3 <= 2); d.mw = 1; d.as = 1; d.imm = 1; d.ac = f3; end
         7'h63: begin ok = !(f3 inside {2, 3}); d.b = 1; d.alu = 1; d.imm = 2; end
         7'h6F: begin d.j = 1; d.rw = 1; d.rs = 2; d.imm = 3; end
         7'h67: begin ok = (f3 == 0); d.j = 1; d.jalr = 1; d.rw = 1; d.rs = 2; d.as = 1; end
         7'h37: begin d.rw = 1; d.as = 1; d.imm = 4; d.alu = 15; end
         default: ok = 0;
      endcase
      if (!ok) d = '0;
      d.ill = !ok;
      d.v   = 1'b1;
      return d;
   endfunction

   task automatic model_reset();
      exp_e = '0; busy_left = 0; exp_cnt = 0;
   endtask

   // Apply one cycle of inputs, predict the next E state, compare after the edge.
   task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
      exp_t nxt;
      exp_t dd;
      int   nbusy;
      InstrD = ins; ValidD = v; StallE = st; FlushE = fl;
      #1;
      check("busy_comb", {31'd0, BusyD}, {31'd0, busy_left > 0});
      nxt = exp_e; nbusy = busy_left; dd = ref_decode(ins);
      if (fl) begin
         nxt = '0; nbusy = 0;
      end else if (busy_left > 0) begin
         nbusy = busy_left - 1;
      end else if (!st) begin
         if (v) begin
            nxt = dd;
            if (dd.ill && exp_cnt < 65535) exp_cnt++;
            if (dd.md && LAT > 1) nbusy = LAT - 1;
         end else begin
            nxt = '0;
         end
      end
      @(posedge clk); #1;
      exp_e = nxt; busy_left = nbusy;
      check("e_regs", {10'd0, obs_e}, {10'd0, exp_e});
      check("illegal_cnt", {16'd0, IllegalCount}, exp_cnt);
      check("busy", {31'd0, BusyD}, {31'd0, busy_left > 0});
   endtask

   initial begin
      logic [6:0]  opc_tab[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h0F};
      logic [6:0]  f7_tab[4]   = '{7'h00, 7'h20, 7'h01, 7'h55};
      logic [31:0] ins;

      #3;
      check("reset_e", {10'd0, obs_e}, 32'd0);
      check("reset_cnt", {16'd0, IllegalCount}, 32'd0);
      check("reset_busy", {31'd0, BusyD}, 32'd0);
      #9 rst_n = 1'b1;
      model_reset();

      step(ADD, 1, 0, 0);
      check("add_regwrite", {31'd0, RegWriteE}, 32'd1);
      check("add_alu", {27'd0, ALUControlE}, 32'd0);
      check("add_valid", {31'd0, ValidE}, 32'd1);

      step(MUL, 1, 0, 0);
      if (MD_ON) begin
         check("mul_md", {31'd0, MulDivE}, 32'd1);
         check("mul_alu", {27'd0, ALUControlE}, 32'd16);
         for (int i = 0; i < 3; i++) begin
            check("mul_busy", {31'd0, BusyD}, 32'd1);
            step(ADD, 1, 0, 0);
            check("mul_hold", {31'd0, MulDivE}, 32'd1);
         end
         check("mul_busy_end", {31'd0, BusyD}, 32'd0);
      end else begin
         check("mul_illegal", {31'd0, IllegalE}, 32'd1);
         check("mul_md_off", {31'd0, MulDivE}, 32'd0);
      end
      step(ADD, 1, 0, 0);
      check("after_mul_md", {31'd0, MulDivE}, 32'd0);

      step(MUL, 1, 0, 0);
      step(ADD, 1, 0, 0);
      step(ADD, 1, 0, 1);
      check("flush_valid", {31'd0, ValidE}, 32'd0);
      check("flush_busy", {31'd0, BusyD}, 32'd0);
      step(ADD, 1, 0, 0);
      check("post_flush_valid", {31'd0, ValidE}, 32'd1);

      step(ADD, 1, 0, 0);
      step(SUB, 1, 1, 0);
      check("stall_alu", {27'd0, ALUControlE}, 32'd0);
      step(SUB, 1, 1, 1);
      check("stall_flush_valid", {31'd0, ValidE}, 32'd0);
      check("stall_flush_rw", {31'd0, RegWriteE}, 32'd0);

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0]   = opc_tab[$urandom_range(0, 9)];
         ins[31:25] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_tab[$urandom_range(0, 3)];
         step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      end

      #3 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      InstrD = 32'hFFFFFFFF; ValidD = 1'b1; StallE = 1'b0; FlushE = 1'b0;
      repeat (65534) @(posedge clk);
      #1 check("cnt_pre_sat", {16'd0, IllegalCount}, 32'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      check("cnt_sat", {16'd0, IllegalCount}, 32'hFFFF);
      check("sat_illegal", {31'd0, IllegalE}, 32'd1);
      check("sat_memwrite", {31'd0, MemWriteE}, 32'd0);
      exp_cnt = 65535;
      exp_e   = ref_decode(32'hFFFFFFFF);

      step(MUL, 1, 0, 0);
      step(ADD, 1, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_e", {10'd0, obs_e}, 32'd0);
      check("async_rst_busy", {31'd0, BusyD}, 32'd0);
      check("async_rst_cnt", {16'd0, IllegalCount}, 32'd0);
      #2 rst_n = 1'b1;
      model_reset();
      step(ADD, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
